// File: rtl/rob_completion_unit.sv
// Reorder buffer back end: allocates entries from dispatch, marks them complete from the
// result ring's ROB tap, and retires finished entries in program order through a registered slot.
module rob_completion_unit #(
  parameter  int XLEN          = 32,
  parameter  int PHYS_REG_SIZE = 256,
  parameter  int ROB_ENTRY     = 256,
  parameter  int ARCH_REG      = 32,
  localparam int PRW           = $clog2(PHYS_REG_SIZE),
  localparam int RBW           = $clog2(ROB_ENTRY),
  localparam int ARW           = $clog2(ARCH_REG)
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            alloc_valid,
  input  logic [PRW-1:0]  alloc_phys_reg,
  input  logic [ARW-1:0]  alloc_arch_reg,
  output logic            alloc_ready,
  output logic [RBW-1:0]  alloc_rob_entry,

  input  logic            ring_valid,
  input  logic [PRW-1:0]  ring_update_reg,
  input  logic [XLEN-1:0] ring_update_val,
  input  logic [RBW-1:0]  ring_rob_entry,

  output logic            retire_valid,
  output logic [ARW-1:0]  retire_arch_reg,
  output logic [PRW-1:0]  retire_phys_reg,
  output logic [XLEN-1:0] retire_val,
  output logic [RBW-1:0]  retire_rob_entry,
  input  logic            retire_ready,

  input  logic            flush,

  output logic [RBW:0]    occupancy,
  output logic            empty,
  output logic            full,
  output logic            err_bad_complete
);

  logic [ROB_ENTRY-1:0] valid_q, valid_d;
  logic [ROB_ENTRY-1:0] done_q, done_d;
  logic [ARW-1:0]       arch_q [ROB_ENTRY];
  logic [ARW-1:0]       arch_d [ROB_ENTRY];
  logic [PRW-1:0]       phys_q [ROB_ENTRY];
  logic [PRW-1:0]       phys_d [ROB_ENTRY];
  logic [XLEN-1:0]      val_q  [ROB_ENTRY];
  logic [XLEN-1:0]      val_d  [ROB_ENTRY];

  logic [RBW-1:0]       head_q, head_d;
  logic [RBW-1:0]       tail_q, tail_d;
  logic [RBW:0]         count_q, count_d;

  logic                 retire_valid_q, retire_valid_d;
  logic [ARW-1:0]       retire_arch_q, retire_arch_d;
  logic [PRW-1:0]       retire_phys_q, retire_phys_d;
  logic [XLEN-1:0]      retire_val_q, retire_val_d;
  logic [RBW-1:0]       retire_rob_q, retire_rob_d;
  logic                 err_q, err_d;

  logic                 alloc_fire;
  logic                 comp_hit;
  logic                 comp_fire;
  logic                 comp_bad;
  logic                 slot_free;
  logic                 pop_fire;

  assign full            = (count_q == (RBW+1)'(ROB_ENTRY));
  assign empty           = (count_q == '0);
  assign occupancy       = count_q;
  assign alloc_ready     = !full && !flush;
  assign alloc_rob_entry = tail_q;

  assign retire_valid     = retire_valid_q;
  assign retire_arch_reg  = retire_arch_q;
  assign retire_phys_reg  = retire_phys_q;
  assign retire_val       = retire_val_q;
  assign retire_rob_entry = retire_rob_q;
  assign err_bad_complete = err_q;

  // A completion aimed at the slot being allocated this very cycle is treated as stale.
  always_comb begin
    alloc_fire = alloc_valid && alloc_ready;
    comp_hit   = valid_q[ring_rob_entry] && !done_q[ring_rob_entry] &&
                 (phys_q[ring_rob_entry] == ring_update_reg) &&
                 !(alloc_fire && (ring_rob_entry == tail_q));
    comp_fire  = ring_valid && !flush && comp_hit;
    comp_bad   = ring_valid && !flush && !comp_hit;
    slot_free  = !retire_valid_q || retire_ready;
    pop_fire   = slot_free && valid_q[head_q] && done_q[head_q] && !flush;
  end

  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    retire_valid_d = retire_valid_q;
    retire_arch_d  = retire_arch_q;
    retire_phys_d  = retire_phys_q;
    retire_val_d   = retire_val_q;
    retire_rob_d   = retire_rob_q;
    err_d          = err_q || comp_bad;

    if (flush) begin
      valid_d        = '0;
      done_d         = '0;
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      retire_valid_d = 1'b0;
    end else begin
      if (comp_fire) begin
        done_d[ring_rob_entry] = 1'b1;
      end

      if (pop_fire) begin
        retire_valid_d  = 1'b1;
        retire_arch_d   = arch_q[head_q];
        retire_phys_d   = phys_q[head_q];
        retire_val_d    = val_q[head_q];
        retire_rob_d    = head_q;
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
      end else if (slot_free) begin
        retire_valid_d = 1'b0;
      end

      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + 1'b1;
      end

      count_d = count_q + (RBW+1)'(alloc_fire) - (RBW+1)'(pop_fire);
    end
  end

  // Payload storage needs no reset: it is only observed behind a set valid/done bit.
  always_comb begin
    arch_d = arch_q;
    phys_d = phys_q;
    val_d  = val_q;
    if (alloc_fire) begin
      arch_d[tail_q] = alloc_arch_reg;
      phys_d[tail_q] = alloc_phys_reg;
    end
    if (comp_fire) begin
      val_d[ring_rob_entry] = ring_update_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_arch_q  <= '0;
      retire_phys_q  <= '0;
      retire_val_q   <= '0;
      retire_rob_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_arch_q  <= retire_arch_d;
      retire_phys_q  <= retire_phys_d;
      retire_val_q   <= retire_val_d;
      retire_rob_q   <= retire_rob_d;
      err_q          <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    arch_q <= arch_d;
    phys_q <= phys_d;
    val_q  <= val_d;
  end

endmodule

// File: doc/rob_completion_unit.md
Name: rob_completion_unit

Overview:
- Receiving end of the result ring's ROB tap. Consumes the ring's ROB broadcast (valid, phys reg, value, ROB entry).
- Marks the matching in-flight ROB entry complete and latches its result.
- Retires completed entries in program order through a registered valid/ready port toward the architectural register file.
- Also owns ROB entry allocation from dispatch and full-pipeline flush.

Parameters:
XLEN, 32, result data width
PHYS_REG_SIZE, 256, physical register count; PRW = $clog2(PHYS_REG_SIZE)
ROB_ENTRY, 256, ROB depth, power of two; RBW = $clog2(ROB_ENTRY)
ARCH_REG, 32, architectural register count; ARW = $clog2(ARCH_REG)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
alloc_valid  in  1  dispatch requests one ROB entry this cycle
alloc_phys_reg  in  PRW  destination phys reg of the allocating uop
alloc_arch_reg  in  ARW  destination arch reg of the allocating uop
alloc_ready  out  1  combinational, = !full && !flush
alloc_rob_entry  out  RBW  combinational, = tail; the index granted when alloc_valid && alloc_ready
ring_valid  in  1  ring ROB tap valid
ring_update_reg  in  PRW  phys reg carried on ring
ring_update_val  in  XLEN  result value on ring
ring_rob_entry  in  RBW  ROB index carried on ring
retire_valid  out  1  registered; retire slot holds a committed result
retire_arch_reg  out  ARW  registered
retire_phys_reg  out  PRW  registered
retire_val  out  XLEN  registered
retire_rob_entry  out  RBW  registered
retire_ready  in  1  consumer accepts the retire slot
flush  in  1  synchronous squash of all in-flight entries
occupancy  out  RBW+1  registered entry count (excludes retire slot)
empty  out  1  occupancy == 0
full  out  1  occupancy == ROB_ENTRY
err_bad_complete  out  1  sticky error flag

Behaviour:
- Storage: per entry valid, done, arch_reg, phys_reg, val. Pointers head and tail are RBW bits and wrap naturally; count is RBW+1 bits.
- Reset (async, rst=1): head=tail=count=0, all valid/done=0, retire_valid=0, retire_* data=0, err_bad_complete=0. Outputs read empty=1, full=0, alloc_ready=1 (if flush=0), alloc_rob_entry=0.
- Allocate on alloc_valid && alloc_ready. At the edge: entry[tail] gets valid=1, done=0, arch/phys regs; tail<=tail+1. alloc_valid while full is ignored and changes no state.
- Complete on ring_valid. Legal when entry[ring_rob_entry].valid=1, done=0 and phys_reg == ring_update_reg. At the edge: done<=1 and val<=ring_update_val.
- Any other completion is ignored and sets err_bad_complete=1 (sticky until rst). This covers: invalid entry, already done, phys reg mismatch, or the entry being allocated in the same cycle.
- Pop: slot_free = !retire_valid || retire_ready. When slot_free && entry[head].valid && entry[head].done, at the edge:
  - copy head into the retire_* registers;
  - retire_valid<=1;
  - entry[head].valid<=0; head<=head+1.
- When slot_free and no pop occurs, retire_valid<=0.
- While retire_valid && !retire_ready, all retire_* outputs hold stable.
- Latency: a completion sampled at edge E on the head entry gives retire_valid=1 after edge E+1. There is no same-cycle bypass from ring to retire.
- Throughput: at most 1 alloc, 1 completion, 1 pop per cycle. count <= count + alloc - pop, so a simultaneous alloc and pop leaves it unchanged.
  - Alloc is permitted when full even if a pop occurs the same cycle? No: alloc_ready is strictly !full.
- Flush (sync, highest priority). At the edge: head=tail=count=0, all valid/done=0, retire_valid=0.
  - Same-cycle alloc, completion and pop are discarded.
  - A ring completion during flush sets no error.
  - err_bad_complete is not cleared by flush.
- Wrap: tail going from ROB_ENTRY-1 to 0 and head doing the same are normal operation.
- Full is exactly count==ROB_ENTRY, which occurs with head==tail.
- Reset asserted mid-operation returns to reset state immediately, regardless of clk.

Test Plan (ROB_ENTRY=8, XLEN=32):
- In-order retire despite out-of-order completion: alloc 3 (rob 0,1,2; phys 10,11,12), then complete rob 2 then 0 then 1 with vals 0x22, 0x00, 0x11 → retire order 0,1,2 with vals 0x00, 0x11, 0x22. rob 0 has retire_valid 2 cycles after its completion cycle.
- Backpressure: hold retire_ready=0 with 3 done entries → retire slot frozen at rob 0, occupancy=2. Release → one retire per cycle, final occupancy=0, empty=1.
- Full/wrap: alloc 8 → full=1, alloc_ready=0, and a 9th alloc_valid changes nothing. Complete/retire rob 0, then alloc → alloc_rob_entry=0 (wrapped), full=1 again.
- Bad completion: ring_valid to unallocated rob 5, then to rob 0 with phys 99 ≠ 10 → err_bad_complete=1, entry states unchanged, and a subsequent legal completion still retires.
- Flush with activity: 4 entries allocated, 2 done, retire slot valid; assert flush with alloc_valid=1 and ring_valid=1 → next cycle occupancy=0, retire_valid=0, alloc_rob_entry=0, err unchanged.
- Async reset mid-stream: assert rst between edges with 5 entries in flight → outputs go to reset values before the next posedge.
